// File: rtl/beep_decoder_pkg.sv
// Shared constants for the tone generator/decoder pair: note half-periods and FSM encoding.
package beep_decoder_pkg;

    typedef enum logic [1:0] {
        StSilent,
        StAcquire,
        StLocked
    } state_e;

    localparam int NumNotes = 7;

    // Half-period minus one, in clk cycles.
    localparam logic [15:0] HalfPeriodDo = 16'd47774;
    localparam logic [15:0] HalfPeriodRi = 16'd42568;
    localparam logic [15:0] HalfPeriodMi = 16'd37919;
    localparam logic [15:0] HalfPeriodFa = 16'd35791;
    localparam logic [15:0] HalfPeriodSo = 16'd31888;
    localparam logic [15:0] HalfPeriodLa = 16'd28410;
    localparam logic [15:0] HalfPeriodXi = 16'd25309;

    typedef logic [NumNotes-1:0][15:0] note_table_t;

    localparam note_table_t NoteTableDefault = {
        HalfPeriodXi, HalfPeriodLa, HalfPeriodSo, HalfPeriodFa,
        HalfPeriodMi, HalfPeriodRi, HalfPeriodDo
    };

    function automatic logic within_tol(input logic [15:0] p, input logic [15:0] t,
                                        input logic [15:0] tol);
        logic [15:0] diff;
        diff = (p >= t) ? (p - t) : (t - p);
        return diff <= tol;
    endfunction

endpackage

// File: rtl/beep_sync.sv
// Two-flop synchronizer for the tone input followed by a registered both-edge detector.
module beep_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic beep_i,
    output logic edge_o
);

    logic sync1_q, sync2_q, prev_q, edge_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= beep_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q ^ prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/beep_decoder.sv
// Measures half-periods of a square-wave tone and locks onto the matching note after
// CONFIRM consecutive agreeing measurements.
module beep_decoder
    import beep_decoder_pkg::*;
#(
    parameter logic [15:0] TOL       = 16'd64,
    parameter logic [2:0]  CONFIRM   = 3'd4,
    parameter logic [15:0] SILENCE   = 16'hFFFF,
    parameter note_table_t NoteTable = NoteTableDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beep_in,
    output logic [2:0] note,
    output logic       note_valid,
    output logic       note_start,
    output logic [7:0] note_count
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  cand_q, cand_d;
    logic [2:0]  mc_q, mc_d;
    logic [2:0]  note_q, note_d;
    logic        valid_q, valid_d;
    logic        start_q, start_d;
    logic [7:0]  count_q, count_d;
    logic        armed_q;

    logic        edge_flag, edge_w, silent_w;
    logic        hit;
    logic [2:0]  idx;
    logic        confirm_w;

    beep_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .beep_i (beep_in),
        .edge_o (edge_flag)
    );

    // Ignore any edge in the first cycle out of reset.
    assign edge_w    = edge_flag & armed_q;
    assign silent_w  = !edge_w && (cnt_q >= SILENCE);
    assign confirm_w = hit && (idx == cand_q) && ((mc_q + 3'd1) == CONFIRM);

    // Scan downwards so the lowest matching index wins.
    always_comb begin
        hit = 1'b0;
        idx = 3'd0;
        for (int k = NumNotes - 1; k >= 0; k--) begin
            if (within_tol(cnt_q, NoteTable[k], TOL)) begin
                hit = 1'b1;
                idx = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StSilent;
            cnt_q   <= 16'd0;
            cand_q  <= 3'd0;
            mc_q    <= 3'd0;
            note_q  <= 3'd0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            count_q <= 8'd0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            mc_q    <= mc_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            start_q <= start_d;
            count_q <= count_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSilent: begin
                if (edge_w) state_d = StAcquire;
            end
            StAcquire: begin
                if (edge_w) begin
                    if (confirm_w) state_d = StLocked;
                end else if (silent_w) begin
                    state_d = StSilent;
                end
            end
            StLocked: begin
                if (edge_w) begin
                    if (!(hit && idx == note_q)) state_d = StAcquire;
                end else if (silent_w) begin
                    state_d = StSilent;
                end
            end
            default: state_d = StSilent;
        endcase
    end

    always_comb begin
        cnt_d   = edge_w ? 16'd0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
        cand_d  = cand_q;
        mc_d    = mc_q;
        note_d  = note_q;
        valid_d = valid_q;
        start_d = 1'b0;
        count_d = count_q;
        unique case (state_q)
            StSilent: begin
                if (edge_w) mc_d = 3'd0;
            end
            StAcquire: begin
                if (edge_w) begin
                    if (hit && idx == cand_q) begin
                        mc_d = mc_q + 3'd1;
                        if (confirm_w) begin
                            note_d  = idx;
                            valid_d = 1'b1;
                            start_d = 1'b1;
                            count_d = count_q + 8'd1;
                        end
                    end else if (hit) begin
                        cand_d = idx;
                        mc_d   = 3'd1;
                    end else begin
                        mc_d = 3'd0;
                    end
                end else if (silent_w) begin
                    valid_d = 1'b0;
                end
            end
            StLocked: begin
                if (edge_w) begin
                    if (!(hit && idx == note_q)) begin
                        valid_d = 1'b0;
                        if (hit) begin
                            cand_d = idx;
                            mc_d   = 3'd1;
                        end else begin
                            mc_d = 3'd0;
                        end
                    end
                end else if (silent_w) begin
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign note       = note_q;
    assign note_valid = valid_q;
    assign note_start = start_q;
    assign note_count = count_q;

endmodule

// File: tb/tb_beep_decoder.sv
// Directed bench for beep_decoder using a scaled-down note table so every scenario fits
// in a short run: do=60 ri=54 mi=46 fa=42 so=36 la=30 xi=20, TOL=2, SILENCE=80.
module tb_beep_decoder;
    import beep_decoder_pkg::*;

    localparam note_table_t TbTable = {
        16'd20, 16'd30, 16'd36, 16'd42, 16'd46, 16'd54, 16'd60
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       beep_in;
    logic [2:0] note;
    logic       note_valid;
    logic       note_start;
    logic [7:0] note_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic prev_start = 1'b0;

    beep_decoder #(
        .TOL       (16'd2),
        .CONFIRM   (3'd4),
        .SILENCE   (16'd80),
        .NoteTable (TbTable)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .beep_in    (beep_in),
        .note       (note),
        .note_valid (note_valid),
        .note_start (note_start),
        .note_count (note_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // n toggles, each followed by period ticks, giving a measured half-period of period-1.
    task automatic toggle_n(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            beep_in = ~beep_in;
            repeat (period) tick();
        end
    endtask

    task automatic quiet();
        repeat (100) tick();
    endtask

    always @(negedge clk) begin
        if (note_start) begin
            n_tests++;
            assert (!prev_start)
            else begin
                n_fail++;
                $error("FAIL start_width: observed %0d expected %0d", 2, 1);
            end
        end
        prev_start <= note_start;
    end

    initial begin
        rst     = 1'b0;
        beep_in = 1'b0;
        repeat (3) tick();
        check("rst_note", note, 0);
        check("rst_valid", note_valid, 0);
        check("rst_start", note_start, 0);
        check("rst_count", note_count, 0);
        rst = 1'b1;
        repeat (5) tick();

        // Lock on la: pulse four cycles after the fifth toggle.
        toggle_n(4, 31);
        beep_in = ~beep_in;
        repeat (3) tick();
        check("lock_pre_start", note_start, 0);
        check("lock_pre_valid", note_valid, 0);
        tick();
        check("lock_start", note_start, 1);
        check("lock_note", note, 5);
        check("lock_valid", note_valid, 1);
        check("lock_count", note_count, 1);
        tick();
        check("lock_pulse_end", note_start, 0);

        // Silence: flag consumed at e4, valid drops at e4+SILENCE+1.
        repeat (79) tick();
        check("sil_valid_hold", note_valid, 1);
        tick();
        check("sil_valid_drop", note_valid, 0);
        check("sil_note_hold", note, 5);

        // Tolerance edge (P=32) locks; one beyond (P=33) does not.
        toggle_n(5, 33);
        check("tol_in_valid", note_valid, 1);
        check("tol_in_note", note, 5);
        check("tol_in_count", note_count, 2);
        quiet();
        check("tol_in_silent", note_valid, 0);
        toggle_n(6, 34);
        check("tol_out_valid", note_valid, 0);
        check("tol_out_count", note_count, 2);
        quiet();

        // P=44 matches both mi and fa; lower index wins.
        toggle_n(5, 45);
        check("low_k_note", note, 2);
        check("low_k_valid", note_valid, 1);
        check("low_k_count", note_count, 3);
        quiet();

        // Note change la -> fa.
        toggle_n(5, 31);
        check("chg_la_note", note, 5);
        check("chg_la_count", note_count, 4);
        repeat (12) tick();
        beep_in = ~beep_in;
        repeat (3) tick();
        check("chg_pre_drop", note_valid, 1);
        tick();
        check("chg_drop", note_valid, 0);
        check("chg_note_hold", note, 5);
        repeat (39) tick();
        toggle_n(2, 43);
        beep_in = ~beep_in;
        repeat (3) tick();
        check("chg_pre_relock", note_valid, 0);
        tick();
        check("chg_start", note_start, 1);
        check("chg_note", note, 3);
        check("chg_count", note_count, 5);

        // Single-cycle reset while locked.
        rst     = 1'b0;
        beep_in = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_note", note, 0);
        check("mid_rst_valid", note_valid, 0);
        check("mid_rst_count", note_count, 0);
        repeat (5) tick();
        toggle_n(4, 31);
        check("mid_rst_no_early", note_valid, 0);
        check("mid_rst_no_early_cnt", note_count, 0);
        beep_in = ~beep_in;
        repeat (4) tick();
        check("mid_rst_relock", note_start, 1);
        check("mid_rst_relock_cnt", note_count, 1);

        // 256 lock/silence rounds wrap the lock counter.
        rst     = 1'b0;
        beep_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            toggle_n(5, 21);
            repeat (70) tick();
            if (i == 254) check("wrap_255", note_count, 255);
        end
        check("wrap_zero", note_count, 0);
        check("wrap_valid", note_valid, 0);
        check("wrap_note", note, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
